// File: rtl/lif_array_scheduler_if.sv
// Spike-event drain port and threshold config bus of lif_array_scheduler.
// master = scheduler side, slave = consumer/host side.
interface lif_array_scheduler_if #(
  parameter int IDX_W = 2,
  parameter int WIDTH = 8
);
  logic             ev_valid;
  logic [IDX_W-1:0] ev_idx;
  logic             ev_ready;
  logic             cfg_we;
  logic [IDX_W-1:0] cfg_addr;
  logic [WIDTH-1:0] cfg_data;

  modport master (
    output ev_valid, ev_idx,
    input  ev_ready, cfg_we, cfg_addr, cfg_data
  );

  modport slave (
    input  ev_valid, ev_idx,
    output ev_ready, cfg_we, cfg_addr, cfg_data
  );
endinterface

// File: rtl/lif_array_scheduler.sv
// Leaky integrate-and-fire update datapath shared across NUM_NEURONS virtual
// neurons, one neuron per clock per timestep, spikes queued in a small FIFO.
//
// state | meaning
// IDLE  | waiting for tick
// SCAN  | updating neuron sidx, one per cycle
// DONE  | one-cycle done pulse, then back to IDLE
module lif_array_scheduler #(
  parameter int NUM_NEURONS = 4,
  parameter int IDX_W       = 2,
  parameter int WIDTH       = 8,
  parameter int LEAK_SHIFT  = 2,
  parameter int REFRACT     = 2,
  parameter int DEF_THR     = 200,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tick,
  output logic [IDX_W-1:0]      cur_idx,
  input  logic [WIDTH-1:0]      cur_data,
  lif_array_scheduler_if.master bus,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic                  tick_miss
);
  localparam int RW = (REFRACT < 1) ? 1 : $clog2(REFRACT + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] PTR_ONE = 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} fsm_t;

  fsm_t             fsm, fsm_nxt;
  logic [IDX_W-1:0] sidx;
  logic [WIDTH-1:0] mem  [NUM_NEURONS];
  logic [WIDTH-1:0] thr  [NUM_NEURONS];
  logic [RW-1:0]    refr [NUM_NEURONS];
  logic [IDX_W-1:0] fifo [FIFO_DEPTH];
  logic [PW:0]      wr_ptr, rd_ptr;

  logic [WIDTH-1:0] s_cur, lk, cur_eff, sat;
  logic [WIDTH:0]   sum;
  logic             refr_act, spike;
  logic             fifo_empty, fifo_full, do_push, do_pop;

  always_ff @(posedge clk) begin
    if (!rst_n) fsm <= IDLE;
    else        fsm <= fsm_nxt;
  end

  always_comb begin
    fsm_nxt = fsm;
    case (fsm)
      IDLE:    if (tick) fsm_nxt = SCAN;
      SCAN:    if (sidx == IDX_W'(NUM_NEURONS - 1)) fsm_nxt = DONE;
      DONE:    fsm_nxt = IDLE;
      default: fsm_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy    = (fsm == SCAN) || (fsm == DONE);
    done    = (fsm == DONE);
    cur_idx = (fsm == SCAN) ? sidx : '0;
  end

  // Refractory neurons integrate zero current and may not fire.
  always_comb begin
    s_cur    = mem[sidx];
    refr_act = (refr[sidx] != '0);
    lk       = s_cur - (s_cur >> LEAK_SHIFT);
    cur_eff  = refr_act ? '0 : cur_data;
    sum      = {1'b0, lk} + {1'b0, cur_eff};
    sat      = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
    spike    = (fsm == SCAN) && !refr_act && (sat >= thr[sidx]);
  end

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign fifo_empty   = (wr_ptr == rd_ptr);
  assign fifo_full    = (wr_ptr[PW] != rd_ptr[PW]) &&
                        (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign do_pop       = bus.ev_ready && !fifo_empty;
  assign do_push      = spike && (!fifo_full || do_pop);
  assign bus.ev_valid = !fifo_empty;
  assign bus.ev_idx   = fifo[rd_ptr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) fifo[wr_ptr[PW-1:0]] <= sidx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sidx      <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ovf       <= 1'b0;
      tick_miss <= 1'b0;
      for (int i = 0; i < NUM_NEURONS; i++) begin
        mem[i]  <= '0;
        thr[i]  <= WIDTH'(DEF_THR);
        refr[i] <= '0;
      end
    end else begin
      if (fsm == SCAN) begin
        sidx <= sidx + IDX_W'(1);
        if (spike) begin
          mem[sidx]  <= '0;
          refr[sidx] <= RW'(REFRACT);
        end else begin
          mem[sidx] <= sat;
          if (refr_act) refr[sidx] <= refr[sidx] - RW'(1);
        end
      end else begin
        sidx <= '0;
      end
      // The update above already sampled the old threshold this cycle.
      if (bus.cfg_we) thr[bus.cfg_addr] <= bus.cfg_data;
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (spike && !do_push) ovf <= 1'b1;
      if (tick && busy) tick_miss <= 1'b1;
    end
  end
endmodule

// File: tb/tb_lif_array_scheduler.sv
// Self-checking bench for lif_array_scheduler: behavioural neuron model feeds
// an expected-event queue that is compared as the FIFO drains.
module tb_lif_array_scheduler;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int W  = 8;
  localparam int LS = 2;
  localparam int RF = 2;
  localparam int DT = 200;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          tick;
  logic [IW-1:0] cur_idx;
  logic [W-1:0]  cur_data;
  logic          busy, done, ovf, tick_miss;
  logic [W-1:0]  cur_tab [N];

  int n_checks = 0;
  int n_pass   = 0;
  int m_state [N];
  int m_thr   [N];
  int m_refr  [N];
  bit m_ovf;
  int exp_q [$];

  lif_array_scheduler_if #(.IDX_W(IW), .WIDTH(W)) bus ();

  lif_array_scheduler #(
    .NUM_NEURONS(N), .IDX_W(IW), .WIDTH(W), .LEAK_SHIFT(LS),
    .REFRACT(RF), .DEF_THR(DT), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .cur_idx(cur_idx),
    .cur_data(cur_data), .bus(bus), .busy(busy), .done(done),
    .ovf(ovf), .tick_miss(tick_miss)
  );

  always #5 clk = ~clk;
  assign cur_data = cur_tab[cur_idx];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_state[i] = 0;
      m_refr[i]  = 0;
      m_thr[i]   = DT;
    end
    m_ovf = 1'b0;
    exp_q.delete();
  endtask

  // One timestep with the consumer stalled for the whole scan.
  task automatic model_scan();
    for (int i = 0; i < N; i++) begin
      int c, lk, s;
      lk = m_state[i] - (m_state[i] >> LS);
      c  = (m_refr[i] != 0) ? 0 : int'(cur_tab[i]);
      s  = lk + c;
      if (s > 255) s = 255;
      if (m_refr[i] == 0 && s >= m_thr[i]) begin
        m_state[i] = 0;
        m_refr[i]  = RF;
        if (exp_q.size() < FD) exp_q.push_back(i);
        else m_ovf = 1'b1;
      end else begin
        m_state[i] = s;
        if (m_refr[i] != 0) m_refr[i]--;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; tick = 1'b0; bus.cfg_we = 1'b0; bus.ev_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic write_thr(input int idx, input int val);
    bus.cfg_we = 1'b1; bus.cfg_addr = IW'(idx); bus.cfg_data = W'(val);
    @(posedge clk); #1;
    bus.cfg_we = 1'b0;
    m_thr[idx] = val;
  endtask

  task automatic set_cur(input int val);
    for (int i = 0; i < N; i++) cur_tab[i] = W'(val);
  endtask

  task automatic run_tick(input string name);
    int lat;
    tick = 1'b1;
    model_scan();
    @(posedge clk); #1;
    tick = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    n_checks++;
    if (done !== 1'b1 || lat != N + 1)
      $display("FAIL %s_latency: done after %0d cycles, want %0d", name, lat, N + 1);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic drain(input string name);
    int guard = 0;
    bus.ev_ready = 1'b1;
    while (bus.ev_valid === 1'b1 && guard < 16) begin
      int e;
      e = -1;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      n_checks++;
      if (int'(bus.ev_idx) !== e)
        $display("FAIL %s_ev_idx: got %0d want %0d", name, bus.ev_idx, e);
      else n_pass++;
      @(posedge clk); #1;
      guard++;
    end
    bus.ev_ready = 1'b0;
    n_checks++;
    if (exp_q.size() != 0)
      $display("FAIL %s_missing: %0d expected events not seen", name, exp_q.size());
    else n_pass++;
    exp_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (bus.ev_valid !== 1'b0) $display("FAIL rst_ev_valid: got %b want 0", bus.ev_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done); else n_pass++;
    n_checks++; if (ovf !== 1'b0) $display("FAIL rst_ovf: got %b want 0", ovf); else n_pass++;
    n_checks++; if (tick_miss !== 1'b0) $display("FAIL rst_tick_miss: got %b want 0", tick_miss); else n_pass++;
    set_cur(0);
    tick = 1'b1;
    model_scan();
    @(posedge clk); #1;
    tick = 1'b0;
    for (int k = 0; k < N; k++) begin
      n_checks++;
      if (cur_idx !== IW'(k) || busy !== 1'b1 || done !== 1'b0)
        $display("FAIL scan_step: cur_idx %0d busy %b done %b, want idx %0d busy 1 done 0", cur_idx, busy, done, k);
      else n_pass++;
      @(posedge clk); #1;
    end
    n_checks++; if (done !== 1'b1 || busy !== 1'b1) $display("FAIL done_pulse: done %b busy %b want 1 1", done, busy); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (done !== 1'b0 || busy !== 1'b0 || cur_idx !== '0) $display("FAIL back_idle: done %b busy %b idx %0d want 0 0 0", done, busy, cur_idx); else n_pass++;
    drain("reset_scan");
  endtask

  task automatic test_threshold();
    do_reset();
    set_cur(6);
    write_thr(2, 10);
    run_tick("thr_t1");
    n_checks++; if (bus.ev_valid !== 1'b0) $display("FAIL thr_t1_nospike: ev_valid %b want 0", bus.ev_valid); else n_pass++;
    run_tick("thr_t2");
    n_checks++; if (bus.ev_valid !== 1'b1 || bus.ev_idx !== 2'd2) $display("FAIL thr_t2_spike: valid %b idx %0d want 1 2", bus.ev_valid, bus.ev_idx); else n_pass++;
    drain("thr");
  endtask

  task automatic test_refractory();
    do_reset();
    set_cur(255);
    for (int i = 0; i < N; i++) write_thr(i, 1);
    for (int t = 1; t <= 8; t++) begin
      logic want;
      want = (t == 1 || t == 4 || t == 7);
      run_tick("refr");
      n_checks++;
      if (bus.ev_valid !== want) $display("FAIL refr_tick%0d: ev_valid %b want %b", t, bus.ev_valid, want);
      else n_pass++;
      drain("refr");
    end
  endtask

  task automatic test_saturation();
    do_reset();
    set_cur(0);
    write_thr(0, 255);
    cur_tab[0] = 8'd250;
    run_tick("sat1");
    n_checks++; if (bus.ev_valid !== 1'b0) $display("FAIL sat_below: ev_valid %b want 0", bus.ev_valid); else n_pass++;
    cur_tab[0] = 8'd200;
    run_tick("sat2");
    n_checks++; if (bus.ev_valid !== 1'b1 || bus.ev_idx !== 2'd0) $display("FAIL sat_spike: valid %b idx %0d want 1 0", bus.ev_valid, bus.ev_idx); else n_pass++;
    drain("sat");
  endtask

  task automatic test_overflow();
    do_reset();
    set_cur(0);
    for (int i = 0; i < N; i++) write_thr(i, 0);
    run_tick("ovf1");
    n_checks++; if (ovf !== 1'b0) $display("FAIL ovf_after_fill: got %b want 0", ovf); else n_pass++;
    for (int t = 2; t <= 4; t++) run_tick("ovf");
    n_checks++; if (ovf !== 1'b1 || m_ovf !== 1'b1) $display("FAIL ovf_set: got %b want 1", ovf); else n_pass++;
    drain("ovf");
    n_checks++; if (ovf !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", ovf); else n_pass++;
  endtask

  task automatic test_cfg_same_cycle();
    int lat;
    do_reset();
    set_cur(0);
    tick = 1'b1;
    model_scan();
    @(posedge clk); #1;
    tick = 1'b0;
    bus.cfg_we = 1'b1; bus.cfg_addr = 2'd0; bus.cfg_data = 8'd0;
    @(posedge clk); #1;
    bus.cfg_we = 1'b0;
    m_thr[0] = 0;
    lat = 2;
    while (done !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    n_checks++; if (lat != N + 1) $display("FAIL cfg_latency: done after %0d want %0d", lat, N + 1); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (bus.ev_valid !== 1'b0) $display("FAIL cfg_old_thr: ev_valid %b want 0", bus.ev_valid); else n_pass++;
    run_tick("cfg");
    n_checks++; if (bus.ev_valid !== 1'b1 || bus.ev_idx !== 2'd0) $display("FAIL cfg_new_thr: valid %b idx %0d want 1 0", bus.ev_valid, bus.ev_idx); else n_pass++;
    drain("cfg");
  endtask

  task automatic test_tick_miss();
    int lat, extra;
    do_reset();
    set_cur(0);
    tick = 1'b1;
    model_scan();
    @(posedge clk); #1;
    tick = 1'b0;
    @(posedge clk); #1;
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
    lat = 3;
    while (done !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    n_checks++; if (lat != N + 1) $display("FAIL miss_latency: done after %0d want %0d", lat, N + 1); else n_pass++;
    n_checks++; if (tick_miss !== 1'b1) $display("FAIL tick_miss_set: got %b want 1", tick_miss); else n_pass++;
    extra = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (busy === 1'b1) extra++;
    end
    n_checks++; if (extra != 0) $display("FAIL no_extra_scan: busy for %0d cycles want 0", extra); else n_pass++;
  endtask

  task automatic test_reset_mid_scan();
    set_cur(0);
    for (int i = 0; i < N; i++) write_thr(i, 0);
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++; if (bus.ev_valid !== 1'b1 || busy !== 1'b1) $display("FAIL mid_scan_pre: valid %b busy %b want 1 1", bus.ev_valid, busy); else n_pass++;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    n_checks++;
    if (bus.ev_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0 || tick_miss !== 1'b0 || cur_idx !== '0)
      $display("FAIL mid_scan_reset: valid %b busy %b done %b ovf %b miss %b idx %0d want all 0",
               bus.ev_valid, busy, done, ovf, tick_miss, cur_idx);
    else n_pass++;
    set_cur(199);
    run_tick("post_rst");
    n_checks++; if (bus.ev_valid !== 1'b0) $display("FAIL thr_restored: ev_valid %b want 0", bus.ev_valid); else n_pass++;
    drain("post_rst");
  endtask

  initial begin
    rst_n = 1'b0; tick = 1'b0;
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0; bus.ev_ready = 1'b0;
    for (int i = 0; i < N; i++) cur_tab[i] = '0;
    model_reset();
    test_reset();
    test_threshold();
    test_refractory();
    test_saturation();
    test_overflow();
    test_cfg_same_cycle();
    test_tick_miss();
    test_reset_mid_scan();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
